// File: rtl/q_ctrl_pkg.sv
// Shared definitions for the Q-learning episode controller: FSM encoding and default terminal state.
package q_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_END  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_t;

  localparam int GOAL_STATE_DEF = 25;

endpackage

// File: rtl/q_episode_ctrl_if.sv
// Host start / datapath step handshake bundle for q_episode_ctrl.
// master = host and datapath side, slave = controller side.
interface q_episode_ctrl_if #(
  parameter int STATE_W = 5,
  parameter int STEP_W  = 4,
  parameter int ITER_W  = 12,
  parameter int EPS_W   = 8
) ();
  logic               start;
  logic [ITER_W-1:0]  total_iteration_in;
  logic               step_valid;
  logic               step_ready;
  logic [STATE_W-1:0] next_state;
  logic               terminal_in;
  logic               busy;
  logic               episode_end;
  logic               done;
  logic [STEP_W-1:0]  step;
  logic [ITER_W-1:0]  iteration;
  logic [ITER_W-1:0]  total_iteration;
  logic [EPS_W-1:0]   epsilon;

  modport master (
    output start, total_iteration_in, step_valid, next_state, terminal_in,
    input  step_ready, busy, episode_end, done, step, iteration, total_iteration, epsilon
  );

  modport slave (
    input  start, total_iteration_in, step_valid, next_state, terminal_in,
    output step_ready, busy, episode_end, done, step, iteration, total_iteration, epsilon
  );
endinterface

// File: rtl/q_eps_decay.sv
// Combinational epsilon decay: eps - (eps >> EPS_SHIFT), clamped from below at EPS_MIN.
// Zero latency, no handshake.
module q_eps_decay #(
  parameter int EPS_W     = 8,
  parameter int EPS_MIN   = 16,
  parameter int EPS_SHIFT = 3
) (
  input  logic [EPS_W-1:0] eps,
  output logic [EPS_W-1:0] eps_next
);
  logic [EPS_W-1:0] dec;

  // Subtracting a right-shifted copy of itself can never underflow.
  assign dec      = eps - (eps >> EPS_SHIFT);
  assign eps_next = (dec < EPS_W'(EPS_MIN)) ? EPS_W'(EPS_MIN) : dec;
endmodule

// File: rtl/q_episode_ctrl.sv
// Episode/step sequencer: counts steps, ends episodes, counts episodes, decays epsilon.
// Outputs decoded from state or registered; steps stall while step_ready is low (outside RUN).
module q_episode_ctrl
  import q_ctrl_pkg::*;
#(
  parameter int STATE_W    = 5,
  parameter int GOAL_STATE = GOAL_STATE_DEF,
  parameter int MAX_STEPS  = 16,
  parameter int STEP_W     = 4,
  parameter int ITER_W     = 12,
  parameter int EPS_W      = 8,
  parameter int EPS_INIT   = 255,
  parameter int EPS_MIN    = 16,
  parameter int EPS_SHIFT  = 3
) (
  input  logic            clk,
  input  logic            rst,
  q_episode_ctrl_if.slave bus
);
  ctrl_state_t       state_q, state_d;
  logic [STEP_W-1:0] step_q;
  logic [ITER_W-1:0] iteration_q;
  logic [ITER_W-1:0] total_q;
  logic [EPS_W-1:0]  eps_q;
  logic [EPS_W-1:0]  eps_dec;

  logic accept;
  logic is_terminal;
  logic step_last;
  logic end_step;
  logic last_episode;

  assign accept       = bus.step_valid && (state_q == ST_RUN);
  assign is_terminal  = (bus.next_state == STATE_W'(GOAL_STATE)) || bus.terminal_in;
  assign step_last    = (step_q == STEP_W'(MAX_STEPS - 1));
  assign end_step     = accept && (is_terminal || step_last);
  assign last_episode = ((iteration_q + ITER_W'(1)) == total_q);

  q_eps_decay #(
    .EPS_W    (EPS_W),
    .EPS_MIN  (EPS_MIN),
    .EPS_SHIFT(EPS_SHIFT)
  ) u_eps_decay (
    .eps     (eps_q),
    .eps_next(eps_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start)
          state_d = (bus.total_iteration_in == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN:  if (end_step) state_d = ST_END;
      ST_END:  state_d = last_episode ? ST_DONE : ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q      <= '0;
      iteration_q <= '0;
      total_q     <= '0;
      eps_q       <= EPS_W'(EPS_INIT);
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            total_q     <= bus.total_iteration_in;
            step_q      <= '0;
            iteration_q <= '0;
            eps_q       <= EPS_W'(EPS_INIT);
          end
        end
        // The ending step leaves step unchanged; it is cleared in END.
        ST_RUN: if (accept && !end_step) step_q <= step_q + STEP_W'(1);
        ST_END: begin
          step_q      <= '0;
          iteration_q <= iteration_q + ITER_W'(1);
          eps_q       <= eps_dec;
        end
        default: ;
      endcase
    end
  end

  assign bus.step_ready      = (state_q == ST_RUN);
  assign bus.busy            = (state_q == ST_RUN) || (state_q == ST_END);
  assign bus.episode_end     = (state_q == ST_END);
  assign bus.done            = (state_q == ST_DONE);
  assign bus.step            = step_q;
  assign bus.iteration       = iteration_q;
  assign bus.total_iteration = total_q;
  assign bus.epsilon         = eps_q;
endmodule

// File: doc/q_episode_ctrl.md
# q_episode_ctrl

Parametrised episode/step controller for the Q-learning accelerator. It sequences training episodes: it counts agent steps, ends an episode on a terminal state or step limit, counts completed episodes up to a programmed total, and decays the exploration rate once per episode. It sits between the host start interface and the agent/Q-table datapath. It gates datapath steps with a valid/ready handshake and emits a one-cycle episode-end strobe for the Q-update writeback.

## Interface

**Parameters**
- STATE_W, 5: width of the environment state index.
- GOAL_STATE, 25: state value treated as terminal.
- MAX_STEPS, 16: maximum accepted steps per episode; must be ≥ 1 and ≤ 2**STEP_W.
- STEP_W, 4: step counter width.
- ITER_W, 12: episode counter width.
- EPS_W, 8: epsilon width, unsigned fraction.
- EPS_INIT, 255: epsilon after reset or start.
- EPS_MIN, 16: epsilon floor.
- EPS_SHIFT, 3: decay shift, eps -= eps >> EPS_SHIFT.

**Ports** (reset rst, synchronous, active-high; clock clk)
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: begin a training run; sampled in IDLE or DONE only.
- total_iteration_in, in, ITER_W: episode count, latched on an accepted start.
- step_valid, in, 1: datapath has completed one agent step.
- step_ready, out, 1: controller accepts steps; high only in RUN.
- next_state, in, STATE_W: state reached by the current step; qualified by step_valid.
- terminal_in, in, 1: external terminal flag, e.g. obstacle; qualified by step_valid.
- busy, out, 1: high in RUN and END.
- episode_end, out, 1: one-cycle strobe, high exactly in END.
- done, out, 1: run complete; held until start or rst.
- step, out, STEP_W: steps accepted in the current episode.
- iteration, out, ITER_W: completed episodes.
- total_iteration, out, ITER_W: latched total.
- epsilon, out, EPS_W: current exploration rate.

## Operation

- A step is accepted when step_valid && step_ready.
- A step is terminal when (next_state == GOAL_STATE) || terminal_in.
- **FSM states:** IDLE, RUN, END, DONE.
- **IDLE / DONE, on start:**
  - Latch total_iteration_in.
  - Set step=0, iteration=0, epsilon=EPS_INIT, done=0.
  - If total_iteration_in == 0: go to DONE with done=1, and no episode_end.
  - Otherwise: go to RUN.
- **RUN, on an accepted step:**
  - If the step is terminal or step == MAX_STEPS-1: go to END; step is unchanged.
  - Otherwise: step += 1.
  - With no accepted step, all counters hold (stall).
- **END, one cycle:**
  - Set step=0 and iteration += 1.
  - Update epsilon to max(eps − (eps >> EPS_SHIFT), EPS_MIN).
  - If iteration+1 == total_iteration: go to DONE with done=1. Otherwise: go back to RUN.
- **start while RUN or END:** ignored.
- **step_valid outside RUN:** ignored; the datapath holds its step.
- **Counters:** never wrap. The iteration bound is exact, and the step bound is enforced by MAX_STEPS.
- **Epsilon arithmetic:** unsigned EPS_W, no overflow possible. The clamp is applied after the subtraction.
- **rst at any time, including mid-episode:** return to IDLE and restore all reset values. rst has priority over start.

## Timing

- **Reset values:** busy=0, step_ready=0, episode_end=0, done=0, step=0, iteration=0, total_iteration=0, epsilon=EPS_INIT, state IDLE.
- **Outputs:** all are registered or decoded directly from the state register, with no combinational input-to-output path.
- **Start:** start sampled at edge t gives busy=1 and step_ready=1 from edge t.
- **Step:** a non-ending step accepted at edge t makes step increment visible after edge t.
- **Episode end:**
  - An ending step at edge t drives episode_end high for cycle [t, t+1), with step_ready low.
  - At edge t+1, iteration and epsilon update and step becomes 0.
  - For the last episode, done rises and busy falls at edge t+1.
- **Episode length:** a full-length episode with continuous step_valid takes MAX_STEPS+1 cycles.

## Structure

- **Shared package q_ctrl_pkg:** FSM state encoding (2 bits) and the default GOAL_STATE constant.
- **Sub-module q_eps_decay:** combinational epsilon next-value, with parameters EPS_W, EPS_MIN, EPS_SHIFT. It is instantiated once.
- **Remainder:** one FSM plus step, iteration and total registers in q_episode_ctrl.

## Test plan

- **Full-length episodes:** start with total=3, step_valid=1 held, next_state never 25 → 3 episode_end pulses 17 cycles apart, with step reaching 15 before each. done=1 and iteration=3 after the third pulse.
- **Early terminal:** next_state=25 accepted at step=4 → END next cycle, then step=0 and iteration=1. The same result follows from terminal_in=1 with next_state=3.
- **Stall and ignored inputs:** step_valid low for 5 cycles at step=6 → step holds at 6. Also, start pulsed mid-run → no effect.
- **Epsilon decay:** successive episodes give epsilon 255→224→196→172. From 18 the next value is 16, and from 16 it stays 16 (clamped).
- **Zero total:** start with total=0 → done=1 next cycle, busy never high, no episode_end.
- **Reset mid-run:** rst at iteration=2, step=7 → all outputs at reset values and state IDLE. A subsequent start with total=1 runs normally.
